lfsr_seq_checker: RTL and testbench
===================================

Name: lfsr_seq_checker

Overview:
- Receive side of the 80-bit LFSR serial link. Samples the generator's serial output one bit per qualified clock and rebuilds the generator state from the stream.
- Once the state is rebuilt, predicts every following bit, declares lock, and counts bit errors.
- Sits at the far end of the serial path and feeds link-quality status to control logic.

Parameters:
- WIDTH, 80, LFSR length in bits.
- TAPS, 80'hC000_0000_0600_0000_0000, feedback mask with taps at bits 79, 78, 42 and 41; identical to the generator's.
- LOCK_CHECK, 16, consecutive correct predictions needed to declare lock.
- LOSS_THRESH, 4, consecutive mispredictions in LOCKED that drop lock.
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low; asserting it (low) clears all state immediately.
- bit_valid  in  1  qualifies ser_in for one cycle; mirrors the generator's shift_en.
- ser_in  in  1  received serial bit; this is the generator's bit 79 before its shift.
- resync  in  1  synchronous request to restart acquisition and clear statistics.
- rec_state  out  WIDTH  recovered shift register R; R[0] is the newest bit.
- locked  out  1  registered lock flag.
- bit_err  out  1  one-cycle pulse marking a mispredicted bit while LOCKED.
- err_count  out  CNT_W  saturating count of mispredictions while LOCKED.

Behaviour:
- Reset (rst low, asynchronous): state ACQ; R = 0; fill, verify and miss counters = 0; locked = 0; bit_err = 0; err_count = 0.
- Prediction: pred = XOR-reduce(R & TAPS). This is combinational from R.
- Only cycles with bit_valid = 1 advance state. With bit_valid = 0, everything holds, and bit_err is 0 on that cycle.
- All outputs are registered and update on the same edge that samples the bit.

ACQ state:
- R <= {R[WIDTH-2:0], ser_in}; fill increments.
- On the WIDTH-th bit: if the new R is all-zero, fill resets to 0 and the state stays ACQ (all-zero is a degenerate state). Otherwise go to VERIFY with verify = 0.

VERIFY state:
- R shifts in ser_in (the received bit, not the prediction).
- If ser_in == pred, verify increments; otherwise verify resets to 0.
- When verify reaches LOCK_CHECK, go to LOCKED, set locked = 1 and reset miss to 0.
- No bit_err pulses and no counting in this state.

LOCKED state (flywheel):
- R shifts in pred, so single errors never corrupt R.
- On a mismatch: bit_err = 1, err_count increments and saturates at all-ones, miss increments.
- On a match: miss resets to 0.
- When miss reaches LOSS_THRESH, on that same edge: locked <= 0, state <= ACQ, fill <= 0, R <= 0.

Other rules:
- rec_state equals the generator seed once WIDTH bits from a freshly loaded generator have been received.
- resync = 1 behaves like reset but synchronously. It beats a simultaneous bit_valid, and that bit is dropped.
- rst low in mid-operation aborts everything immediately. After release, the block resumes in ACQ.

Decomposition:
- Shared package lfsr_pkg holds: LFSR_WIDTH = 80, LFSR_TAPS, and the state enum {ACQ, VERIFY, LOCKED} as a 2-bit encoding.
- The generator and the checker both take their taps from this package.
- Sub-module lfsr_predict: purely combinational, computes pred from R and TAPS. It is reusable by the generator's feedback.
- Counter widths are derived with $clog2.

Test Plan:
1. Hold rst low mid-stream with bit_valid toggling -> immediately locked = 0, err_count = 0, rec_state = 0. After release, the state is ACQ.
2. Generator loaded with 80'h123456789ABCDEF01234, 80 valid bits -> rec_state = 80'h123456789ABCDEF01234 and locked = 0. After 16 more correct bits, locked = 1 on the edge sampling bit 96.
3. Locked, invert one bit -> bit_err pulses for 1 cycle, err_count = 1, locked stays 1, and the next 50 bits produce no errors.
4. Locked, invert 4 consecutive bits -> err_count = 4 and locked = 0 on the 4th. The block relocks after 96 further clean bits with err_count still 4.
5. Drop bit_valid for 3 cycles mid-acquisition while ser_in toggles -> rec_state and counters are unchanged. The lock point shifts by exactly 3 cycles.
6. Feed 80 zero bits -> the state stays ACQ and locked = 0. Then assert resync together with bit_valid = 1 -> the bit is dropped and err_count = 0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 80-bit LFSR serial link: register length, feedback
// taps and the receive-side acquisition state encoding.
package lfsr_pkg;

    localparam int                LFSR_WIDTH = 80;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 80'hC000_0000_0600_0000_0000;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_e;

endpackage

// File: rtl/lfsr_predict.sv
// Next-bit predictor: parity of the tapped register bits. Shared between the
// generator feedback path and the receive-side checker.
module lfsr_predict #(
    parameter int               WIDTH = 80,
    parameter logic [WIDTH-1:0] TAPS  = '0
) (
    input  logic [WIDTH-1:0] state,
    output logic             pred
);

    assign pred = ^(state & TAPS);

endmodule

// File: rtl/lfsr_seq_checker.sv
// Receive side of the LFSR link: rebuilds the generator state from the serial
// stream, verifies predictions before declaring lock, then flywheels and counts errors.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH       = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS        = LFSR_TAPS,
    parameter int               LOCK_CHECK  = 16,
    parameter int               LOSS_THRESH = 4,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             ser_in,
    input  logic             resync,
    output logic [WIDTH-1:0] rec_state,
    output logic             locked,
    output logic             bit_err,
    output logic [CNT_W-1:0] err_count
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int VER_W  = $clog2(LOCK_CHECK + 1);
    localparam int MISS_W = $clog2(LOSS_THRESH + 1);

    lfsr_state_e      state_q,     state_d;
    logic [WIDTH-1:0] r_q,         r_d;
    logic [FILL_W-1:0] fill_q,     fill_d;
    logic [VER_W-1:0] verify_q,    verify_d;
    logic [MISS_W-1:0] miss_q,     miss_d;
    logic             locked_q,    locked_d;
    logic             bit_err_q,   bit_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             pred;
    logic [WIDTH-1:0] r_shift;

    lfsr_predict #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_predict (
        .state (r_q),
        .pred  (pred)
    );

    assign r_shift = {r_q[WIDTH-2:0], ser_in};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        r_d         = r_q;
        fill_d      = fill_q;
        verify_d    = verify_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        bit_err_d   = 1'b0;
        err_count_d = err_count_q;

        if (resync) begin
            state_d     = ACQ;
            r_d         = '0;
            fill_d      = '0;
            verify_d    = '0;
            miss_d      = '0;
            locked_d    = 1'b0;
            err_count_d = '0;
        end else if (bit_valid) begin
            case (state_q)
                ACQ: begin
                    r_d = r_shift;
                    if (fill_q == FILL_W'(WIDTH - 1)) begin
                        // An all-zero register would predict zeros forever; refill instead.
                        fill_d = '0;
                        if (r_shift != '0) begin
                            state_d  = VERIFY;
                            verify_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end

                VERIFY: begin
                    r_d = r_shift;
                    if (ser_in == pred) begin
                        if (verify_q == VER_W'(LOCK_CHECK - 1)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            miss_d   = '0;
                            verify_d = '0;
                        end else begin
                            verify_d = verify_q + VER_W'(1);
                        end
                    end else begin
                        verify_d = '0;
                    end
                end

                LOCKED: begin
                    // Flywheel: the register follows its own prediction, so line errors never enter it.
                    r_d = {r_q[WIDTH-2:0], pred};
                    if (ser_in != pred) begin
                        bit_err_d = 1'b1;
                        if (err_count_q != {CNT_W{1'b1}}) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                        if (miss_q == MISS_W'(LOSS_THRESH - 1)) begin
                            state_d  = ACQ;
                            locked_d = 1'b0;
                            fill_d   = '0;
                            r_d      = '0;
                            miss_d   = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end

                default: begin
                    state_d = ACQ;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ACQ;
            r_q         <= '0;
            fill_q      <= '0;
            verify_q    <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            bit_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            fill_q      <= fill_d;
            verify_q    <= verify_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            bit_err_q   <= bit_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign rec_state = r_q;
    assign locked    = locked_q;
    assign bit_err   = bit_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Self-checking bench for lfsr_seq_checker: a behavioural generator feeds the link,
// a reference model fills a scoreboard, and directed tasks check the key milestones.
module tb_lfsr_seq_checker;

    localparam int               W       = 80;
    localparam logic [W-1:0]     TB_TAPS = 80'hC000_0000_0600_0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          bit_valid;
    logic          ser_in;
    logic          resync;
    logic [W-1:0]  rec_state;
    logic          locked;
    logic          bit_err;
    logic [15:0]   err_count;

    lfsr_seq_checker dut (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .ser_in    (ser_in),
        .resync    (resync),
        .rec_state (rec_state),
        .locked    (locked),
        .bit_err   (bit_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         locked;
        logic         bit_err;
        logic [15:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Generator and reference checker model
    logic [W-1:0] g;
    int           m_st;
    logic [W-1:0] m_r;
    int           m_fill, m_ver, m_miss;
    logic         m_locked, m_bit_err;
    logic [15:0]  m_cnt;

    task automatic model_reset();
        m_st = 0; m_r = '0; m_fill = 0; m_ver = 0; m_miss = 0;
        m_locked = 1'b0; m_bit_err = 1'b0; m_cnt = '0;
    endtask

    task automatic model_step(input logic v, input logic b, input logic rs);
        logic p;
        p = ^(m_r & TB_TAPS);
        m_bit_err = 1'b0;
        if (rs) begin
            model_reset();
        end else if (v) begin
            case (m_st)
                0: begin
                    m_r = {m_r[W-2:0], b};
                    m_fill++;
                    if (m_fill == W) begin
                        m_fill = 0;
                        if (m_r != '0) begin m_st = 1; m_ver = 0; end
                    end
                end
                1: begin
                    m_r = {m_r[W-2:0], b};
                    if (b == p) m_ver++; else m_ver = 0;
                    if (m_ver == 16) begin m_st = 2; m_locked = 1'b1; m_miss = 0; m_ver = 0; end
                end
                default: begin
                    m_r = {m_r[W-2:0], p};
                    if (b != p) begin
                        m_bit_err = 1'b1;
                        if (m_cnt != 16'hFFFF) m_cnt++;
                        m_miss++;
                        if (m_miss == 4) begin
                            m_locked = 1'b0; m_st = 0; m_fill = 0; m_r = '0; m_miss = 0;
                        end
                    end else begin
                        m_miss = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic rs);
        exp_t e;
        @(negedge clk);
        bit_valid = v;
        ser_in    = b;
        resync    = rs;
        model_step(v, b, rs);
        e.r = m_r; e.locked = m_locked; e.bit_err = m_bit_err; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic gen_bit(input logic flip);
        drive(1'b1, g[W-1] ^ flip, 1'b0);
        g = {g[W-2:0], ^(g & TB_TAPS)};
    endtask

    // Scoreboard: compare each edge's outputs against the model prediction
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (rec_state !== mon_e.r || locked !== mon_e.locked ||
                bit_err !== mon_e.bit_err || err_count !== mon_e.cnt) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got r=%h lk=%b be=%b cnt=%0d, expected r=%h lk=%b be=%b cnt=%0d",
                         $time, rec_state, locked, bit_err, err_count,
                         mon_e.r, mon_e.locked, mon_e.bit_err, mon_e.cnt);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0; bit_valid = 1'b0; ser_in = 1'b0; resync = 1'b0;
        model_reset();
        #3;
        checks++;
        if (rec_state !== '0 || locked !== 1'b0 || bit_err !== 1'b0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got r=%h lk=%b be=%b cnt=%0d, expected all zero",
                     rec_state, locked, bit_err, err_count);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_acquire();
        g = 80'h1234_5678_9ABC_DEF0_1234;
        for (int i = 0; i < 80; i++) gen_bit(1'b0);
        checks++;
        if (rec_state !== 80'h1234_5678_9ABC_DEF0_1234 || locked !== 1'b0) begin
            errors++;
            $display("FAIL acquire_seed: got r=%h lk=%b, expected r=123456789abcdef01234 lk=0", rec_state, locked);
        end
        for (int i = 1; i <= 16; i++) begin
            gen_bit(1'b0);
            if (i == 15) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL early_lock: got locked=%b at bit 95, expected 0", locked); end
            end
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL lock_at_96: got locked=%b, expected 1", locked); end
    endtask

    task automatic test_single_error();
        int pulses;
        gen_bit(1'b1);
        checks++;
        if (bit_err !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL single_err: got be=%b cnt=%0d lk=%b, expected be=1 cnt=1 lk=1", bit_err, err_count, locked);
        end
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            gen_bit(1'b0);
            if (bit_err) pulses++;
        end
        checks++;
        if (pulses != 0 || err_count !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL after_single: got pulses=%0d cnt=%0d lk=%b, expected 0 1 1", pulses, err_count, locked);
        end
    endtask

    task automatic test_loss_relock();
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 96; i++) gen_bit(1'b0);
        for (int i = 1; i <= 4; i++) begin
            gen_bit(1'b1);
            if (i == 3) begin
                checks++;
                if (locked !== 1'b1) begin errors++; $display("FAIL loss_early: got locked=%b after 3 misses, expected 1", locked); end
            end
        end
        checks++;
        if (locked !== 1'b0 || err_count !== 16'd4 || rec_state !== '0) begin
            errors++;
            $display("FAIL loss_on_4th: got lk=%b cnt=%0d r=%h, expected lk=0 cnt=4 r=0", locked, err_count, rec_state);
        end
        for (int i = 1; i <= 96; i++) begin
            gen_bit(1'b0);
            if (i == 95) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL relock_early: got locked=%b at bit 95, expected 0", locked); end
            end
        end
        checks++;
        if (locked !== 1'b1 || err_count !== 16'd4) begin
            errors++;
            $display("FAIL relock: got lk=%b cnt=%0d, expected lk=1 cnt=4", locked, err_count);
        end
    endtask

    task automatic test_valid_gap();
        logic [W-1:0] snap;
        int cyc;
        drive(1'b0, 1'b0, 1'b1);
        g = 80'hA5C3_0F1E_2D3C_4B5A_6978;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin gen_bit(1'b0); cyc++; end
        snap = rec_state;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, k[0] ^ 1'b1, 1'b0);
            cyc++;
            checks++;
            if (rec_state !== snap || bit_err !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold: got r=%h be=%b, expected r=%h be=0", rec_state, bit_err, snap);
            end
        end
        for (int i = 0; i < 40; i++) begin gen_bit(1'b0); cyc++; end
        checks++;
        if (rec_state !== 80'hA5C3_0F1E_2D3C_4B5A_6978) begin
            errors++;
            $display("FAIL gap_seed: got r=%h, expected a5c30f1e2d3c4b5a6978", rec_state);
        end
        while (!locked && cyc < 200) begin gen_bit(1'b0); cyc++; end
        checks++;
        if (cyc != 99) begin errors++; $display("FAIL gap_lock_point: got lock after %0d cycles, expected 99", cyc); end
    endtask

    task automatic test_zero_fill();
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 80; i++) drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b0 || rec_state !== '0) begin
            errors++;
            $display("FAIL zero_fill: got lk=%b r=%h, expected lk=0 r=0", locked, rec_state);
        end
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (rec_state !== '0 || err_count !== 16'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL resync_drop: got r=%h cnt=%0d lk=%b, expected 0 0 0", rec_state, err_count, locked);
        end
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (rec_state !== 80'd1) begin errors++; $display("FAIL resync_acq: got r=%h, expected 1", rec_state); end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b0, 1'b1);
        g = 80'h0F0F_1234_FFFF_0000_8001;
        for (int i = 0; i < 96; i++) gen_bit(1'b0);
        gen_bit(1'b1);
        checks++;
        if (locked !== 1'b1 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL pre_reset: got lk=%b cnt=%0d, expected lk=1 cnt=1", locked, err_count);
        end
        bit_valid = 1'b1; ser_in = 1'b1;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (locked !== 1'b0 || err_count !== 16'd0 || rec_state !== '0 || bit_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got lk=%b cnt=%0d r=%h be=%b, expected all zero", locked, err_count, rec_state, bit_err);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bit_valid = ~bit_valid;
            ser_in = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
            checks++;
            if (locked !== 1'b0 || err_count !== 16'd0 || rec_state !== '0) begin
                errors++;
                $display("FAIL reset_hold: got lk=%b cnt=%0d r=%h, expected all zero", locked, err_count, rec_state);
            end
        end
        @(negedge clk);
        bit_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        g = 80'h1234_5678_9ABC_DEF0_1234;
        for (int i = 0; i < 80; i++) gen_bit(1'b0);
        checks++;
        if (rec_state !== 80'h1234_5678_9ABC_DEF0_1234 || locked !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_acq: got r=%h lk=%b, expected r=123456789abcdef01234 lk=0", rec_state, locked);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_acquire();
        test_single_error();
        test_loss_relock();
        test_valid_gap();
        test_zero_fill();
        test_async_reset();
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
